// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring
// divide on operand magnitudes, with a single sign fix-up cycle before HI/LO load.
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO write HI/LO directly here
// CALC  | one shift-add or shift-subtract step per cycle, ITER cycles
// FIX   | sign fix-up, load HI/LO, pulse Done on the following cycle
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             Clk,
   input  logic             Clr_n,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] dataRS,
   input  logic [WIDTH-1:0] dataRT,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             Busy,
   output logic             Done
);

   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_t;

   state_t state, state_nxt;

   logic                 is_div;
   logic                 sign_a;
   logic                 sign_b;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   acc;
   logic [CNT_W-1:0]     cnt;

   logic                 req_md;
   logic                 req_signed;
   logic                 in_sign_a;
   logic                 in_sign_b;
   logic [WIDTH-1:0]     in_mag_a;
   logic [WIDTH-1:0]     in_mag_b;

   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_rem_sh;
   logic [WIDTH+1:0]     div_diff;
   logic [2*WIDTH-1:0]   div_next;

   logic [2*WIDTH-1:0]   mul_res;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic                 div_zero;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   assign Busy = (state != S_IDLE);

   // Operand capture: signed ops (Op[0]=0) take magnitudes and keep the sign bits.
   always_comb begin
      req_md     = Start && !Op[2];
      req_signed = !Op[0];
      in_sign_a  = req_signed && dataRS[WIDTH-1];
      in_sign_b  = req_signed && dataRT[WIDTH-1];
      in_mag_a   = in_sign_a ? -dataRS : dataRS;
      in_mag_b   = in_sign_b ? -dataRT : dataRT;
   end

   // One iteration of each algorithm; acc = {upper, lower} halves.
   always_comb begin
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
      mul_next   = {mul_sum, acc[WIDTH-1:1]};
      div_rem_sh = acc[2*WIDTH-1:WIDTH-1];
      div_diff   = {1'b0, div_rem_sh} - {2'b00, b_mag};
      if (div_diff[WIDTH+1])
         div_next = {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // With a zero divisor every restoring step succeeds, so the remainder ends up
   // as the dividend magnitude; re-applying sign A recovers the raw dataRS.
   always_comb begin
      mul_res  = (sign_a ^ sign_b) ? -acc : acc;
      quo      = acc[WIDTH-1:0];
      rem      = acc[2*WIDTH-1:WIDTH];
      div_zero = (b_mag == '0);
      fix_hi   = sign_a ? -rem : rem;
      if (div_zero)
         fix_lo = '1;
      else
         fix_lo = (sign_a ^ sign_b) ? -quo : quo;
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (req_md) state_nxt = S_CALC;
         S_CALC: if (cnt == '0) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         HI     <= '0;
         LO     <= '0;
         Done   <= 1'b0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_mag  <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_md) begin
                  is_div <= Op[1];
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  b_mag  <= in_mag_b;
                  acc    <= {{WIDTH{1'b0}}, in_mag_a};
                  cnt    <= CNT_LOAD;
               end else if (Start && (Op[2:1] == 2'b10)) begin
                  if (Op[0])
                     LO <= dataRS;
                  else
                     HI <= dataRS;
               end
            end
            S_CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               if (is_div) begin
                  HI <= fix_hi;
                  LO <= fix_lo;
               end else begin
                  HI <= mul_res[2*WIDTH-1:WIDTH];
                  LO <= mul_res[WIDTH-1:0];
               end
               Done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of mult/div vectors plus hand-written
// sequences for MTHI/MTLO, ignored requests, back-to-back issue and mid-op reset.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         Clr_n;
   logic         Start;
   logic [2:0]   Op;
   logic [W-1:0] dataRS;
   logic [W-1:0] dataRT;
   logic [W-1:0] HI;
   logic [W-1:0] LO;
   logic         Busy;
   logic         Done;

   int n_pass  = 0;
   int n_total = 0;

   mult_div_unit #(.WIDTH(W), .ITER(32)) dut (
      .Clk(Clk), .Clr_n(Clr_n), .Start(Start), .Op(Op),
      .dataRS(dataRS), .dataRT(dataRT),
      .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                          OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

   vec_t vecs[12];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Called just after a rising edge; Start is sampled at the next edge (edge 0).
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      Start  = 1'b1;
      Op     = op;
      dataRS = a;
      dataRT = b;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   // Returns edges after edge 0 until Done is seen (0 on timeout) and Busy-high samples.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = Busy ? 1 : 0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge Clk); #1;
         if (Done) begin
            lat = i;
            break;
         end
         if (Busy) busy_cnt++;
      end
   endtask

   initial begin
      int lat, bc;
      logic [W-1:0] hold_hi, hold_lo;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[4]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[7]  = '{OP_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
      vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      vecs[10] = '{OP_MULT,  32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};
      vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

      Clr_n = 1'b0; Start = 1'b0; Op = 3'b111; dataRS = '0; dataRT = '0;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_hi", HI, '0);
      check("reset_lo", LO, '0);
      check("reset_busy", W'(Busy), '0);
      check("reset_done", W'(Done), '0);
      Clr_n = 1'b1;
      @(posedge Clk); #1;

      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(lat, bc);
         check($sformatf("vec%0d_latency", i), W'(lat), W'(33));
         check($sformatf("vec%0d_busy_cycles", i), W'(bc), W'(33));
         check($sformatf("vec%0d_busy_at_done", i), W'(Busy), '0);
         check($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
         check($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
         @(posedge Clk); #1;
         check($sformatf("vec%0d_done_pulse", i), W'(Done), '0);
      end

      // MTHI then MTLO on consecutive edges
      Start = 1'b1; Op = OP_MTHI; dataRS = 32'hAAAA5555;
      @(posedge Clk); #1;
      check("mthi_hi", HI, 32'hAAAA5555);
      check("mthi_busy", W'(Busy), '0);
      check("mthi_done", W'(Done), '0);
      Op = OP_MTLO; dataRS = 32'h00001234;
      @(posedge Clk); #1;
      Start = 1'b0;
      check("mtlo_lo", LO, 32'h00001234);
      check("mtlo_hi_kept", HI, 32'hAAAA5555);
      check("mtlo_busy", W'(Busy), '0);
      check("mtlo_done", W'(Done), '0);

      // Op=11x is a no-op
      Start = 1'b1; Op = 3'b110; dataRS = 32'h55555555; dataRT = 32'h3;
      @(posedge Clk); #1;
      Start = 1'b0;
      check("noop_hi", HI, 32'hAAAA5555);
      check("noop_lo", LO, 32'h00001234);
      check("noop_busy", W'(Busy), '0);

      // Requests and operand changes while busy are ignored
      issue(OP_MULTU, 32'd3, 32'd5);
      repeat (4) @(posedge Clk);
      #1;
      Start = 1'b1; Op = OP_MTLO; dataRS = 32'hDEADBEEF; dataRT = 32'd9;
      @(posedge Clk); #1;
      check("busy_mtlo_lo_kept", LO, 32'h00001234);
      Op = OP_MULTU; dataRS = 32'd99;
      @(posedge Clk); #1;
      Start = 1'b0;
      wait_done(lat, bc);
      check("busy_ignore_latency", W'(lat), W'(27));
      check("busy_ignore_hi", HI, 32'd0);
      check("busy_ignore_lo", LO, 32'd15);
      @(posedge Clk); #1;
      check("busy_ignore_no_requeue", W'(Busy), '0);

      // Back-to-back: new Start in the Done cycle is accepted
      issue(OP_MULTU, 32'd6, 32'd7);
      wait_done(lat, bc);
      check("b2b_first_lo", LO, 32'd42);
      check("b2b_first_done", W'(Done), W'(1));
      issue(OP_MULTU, 32'h00010000, 32'h00010000);
      check("b2b_busy_next", W'(Busy), W'(1));
      wait_done(lat, bc);
      check("b2b_latency", W'(lat), W'(33));
      check("b2b_hi", HI, 32'h00000001);
      check("b2b_lo", LO, 32'h00000000);

      // Reset mid-operation aborts, then a rerun gives the full result
      issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
      repeat (9) @(posedge Clk);
      #1;
      hold_hi = HI;
      hold_lo = LO;
      check("pre_reset_lo_held", hold_lo, 32'h00000000);
      check("pre_reset_hi_held", hold_hi, 32'h00000001);
      Clr_n = 1'b0;
      #1;
      check("midreset_hi", HI, '0);
      check("midreset_lo", LO, '0);
      check("midreset_busy", W'(Busy), '0);
      check("midreset_done", W'(Done), '0);
      @(posedge Clk); #1;
      Clr_n = 1'b1;
      @(posedge Clk); #1;
      check("post_reset_idle", W'(Busy), '0);
      issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
      wait_done(lat, bc);
      check("rerun_latency", W'(lat), W'(33));
      check("rerun_hi", HI, 32'hFFFFFFFF);
      check("rerun_lo", LO, 32'hFFFFFFEB);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the register file's dataRS/dataRT outputs.
- Executes MULT, MULTU, DIV, DIVU over multiple cycles and holds results in HI/LO.
- MTHI/MTLO write HI/LO directly. The HI/LO outputs feed the MFHI/MFLO path back to the register-file write port.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- ITER, 32, number of CALC iterations. Must equal WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Clr_n  input  1  asynchronous active-low reset.
- Start  input  1  operation request; sampled only when Busy=0.
- Op  input  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- dataRS  input  WIDTH  operand A / dividend / MTHI-MTLO source.
- dataRT  input  WIDTH  operand B / divisor.
- HI  output  WIDTH  high product / remainder.
- LO  output  WIDTH  low product / quotient.
- Busy  output  1  high while a mult/div is in progress.
- Done  output  1  one-cycle pulse when HI/LO receive a mult/div result.

Behaviour:
- Interface: one clock (Clk); reset is asynchronous and active-low (Clr_n).
- Reset: Clr_n=0 immediately forces HI=0, LO=0, Busy=0, Done=0, state IDLE and clears internal operand and accumulator registers. Reset mid-operation aborts with no partial HI/LO update.
- States: IDLE, CALC, FIX.
- IDLE, Start=1, Op=MULT/MULTU/DIV/DIVU:
  - At the edge, latch dataRS, dataRT and Op. Load iteration counter = ITER-1.
  - Go to CALC; Busy=1 from this edge.
  - Signed ops latch absolute values plus both sign bits.
- IDLE, Start=1, Op=MTHI/MTLO:
  - At the edge, HI (resp. LO) <= dataRS. Stay IDLE; Busy and Done remain 0.
- IDLE, Start=1, Op=11x: no effect.
- CALC, multiply: one shift-add step per cycle on a 2*WIDTH accumulator (unsigned on magnitudes).
- CALC, divide: one restoring shift-subtract step per cycle (unsigned on magnitudes).
- CALC exit: counter decrements each cycle. When it reaches 0, go to FIX after that cycle's step (exactly ITER CALC cycles).
- FIX, single cycle:
  - Signed sign fix-up: MULT negates the 64-bit product if sign A xor sign B. DIV negates the quotient if sign A xor sign B and negates the remainder if sign A.
  - Load {HI,LO}. Multiply: HI = upper half, LO = lower half. Divide: HI = remainder, LO = quotient.
  - Done=1 for exactly the following cycle. Busy=0 and state IDLE after this edge.
- Latency: Start sampled at edge 0 → HI/LO valid and Done=1 after edge ITER+1 (edge 33 at default). Busy is high for ITER+1 cycles.
- Start while Busy=1 is ignored, including MTHI/MTLO; no queuing. Operand changes on dataRS/dataRT during Busy have no effect.
- Start=1 in the same cycle Done=1: accepted, since state is IDLE and Busy=0.
- Divide by zero (DIV or DIVU): completes with normal latency. HI = latched dataRS unmodified, LO = 32'hFFFFFFFF; sign fix-up is suppressed.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- HI/LO hold their value between operations. Done never asserts for MTHI/MTLO or for ignored requests.

Test Plan:
- Reset then MULTU dataRS=0xFFFFFFFF, dataRT=0xFFFFFFFF → Busy high for 33 cycles; Done pulse after edge 33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT dataRS=0xFFFFFFFD (-3), dataRT=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21); reset-then-retry with Clr_n=0 pulsed at cycle 10 → HI=LO=0, Busy=0 immediately, then rerun gives the same result.
- DIV dataRS=0xFFFFFFF9 (-7), dataRT=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/7 → LO=14, HI=2.
- DIVU 0x12345678/0 → HI=0x12345678, LO=0xFFFFFFFF after 33 cycles; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0xAAAA5555 then MTLO 0x1234 on consecutive cycles → HI/LO update on each edge, Done/Busy stay 0; MTLO issued while Busy → LO unchanged.
- Back-to-back: new MULTU Start=1 asserted in the Done cycle → accepted, Busy=1 next cycle; Start pulses during Busy → ignored, result unaffected.
